// File: rtl/vga_rect_plotter.sv
// Rectangle / clear-screen pixel generator feeding the VGA adapter write port.
// Latches a box command, then emits one registered pixel write per clock in raster order.
module vga_rect_plotter #(
    parameter int X_SCREEN_PIXELS = 160,
    parameter int Y_SCREEN_PIXELS = 120,
    parameter int X_WIDTH         = 8,
    parameter int Y_WIDTH         = 7,
    parameter int COLOUR_WIDTH    = 3,
    parameter int SIZE_WIDTH      = 5
) (
    input  logic                    iClock,
    input  logic                    iResetn,
    input  logic                    iLoadX,
    input  logic                    iPlotBox,
    input  logic                    iBlack,
    input  logic [X_WIDTH-1:0]      iXY_Coord,
    input  logic [COLOUR_WIDTH-1:0] iColour,
    input  logic [SIZE_WIDTH-1:0]   iBoxW,
    input  logic [SIZE_WIDTH-1:0]   iBoxH,
    input  logic                    iOutline,
    output logic [X_WIDTH-1:0]      oX,
    output logic [Y_WIDTH-1:0]      oY,
    output logic [COLOUR_WIDTH-1:0] oColour,
    output logic                    oPlot,
    output logic                    oDone
);
    localparam int CX_W = $clog2(X_SCREEN_PIXELS);
    localparam int CY_W = $clog2(Y_SCREEN_PIXELS);
    localparam logic [X_WIDTH:0]  X_LIM   = (X_WIDTH+1)'(X_SCREEN_PIXELS);
    localparam logic [Y_WIDTH:0]  Y_LIM   = (Y_WIDTH+1)'(Y_SCREEN_PIXELS);
    localparam logic [CX_W-1:0]   CX_LAST = CX_W'(X_SCREEN_PIXELS - 1);
    localparam logic [CY_W-1:0]   CY_LAST = CY_W'(Y_SCREEN_PIXELS - 1);

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_CLEAR, S_DONE} state_t;

    state_t                  r_state;
    logic [X_WIDTH-1:0]      r_x;
    logic [Y_WIDTH-1:0]      r_y;
    logic [COLOUR_WIDTH-1:0] r_colour;
    logic [SIZE_WIDTH-1:0]   r_w;
    logic [SIZE_WIDTH-1:0]   r_h;
    logic                    r_outline;
    logic [SIZE_WIDTH-1:0]   r_col;
    logic [SIZE_WIDTH-1:0]   r_row;
    logic [CX_W-1:0]         r_cx;
    logic [CY_W-1:0]         r_cy;
    logic                    r_scan_end;

    logic [X_WIDTH:0] w_px;
    logic [Y_WIDTH:0] w_py;
    logic             w_clip;
    logic             w_col_last;
    logic             w_row_last;
    logic             w_border;
    logic             w_on;
    logic             w_accepting;

    // Sums are one bit wider than the outputs so off-screen pixels cannot wrap back on.
    assign w_px        = (X_WIDTH+1)'(r_x) + (X_WIDTH+1)'(r_col);
    assign w_py        = (Y_WIDTH+1)'(r_y) + (Y_WIDTH+1)'(r_row);
    assign w_clip      = (w_px >= X_LIM) || (w_py >= Y_LIM);
    assign w_col_last  = (r_col == r_w - SIZE_WIDTH'(1));
    assign w_row_last  = (r_row == r_h - SIZE_WIDTH'(1));
    assign w_border    = (r_col == '0) || w_col_last || (r_row == '0) || w_row_last;
    assign w_on        = !w_clip && (!r_outline || w_border);
    assign w_accepting = (r_state == S_IDLE) || (r_state == S_DONE);

    // NOTE: every register here uses non-blocking assignment so all state updates
    // see the pre-edge values; blocking assignments would make order matter.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            r_state    <= S_IDLE;
            r_x        <= '0;
            r_y        <= '0;
            r_colour   <= '0;
            r_w        <= '0;
            r_h        <= '0;
            r_outline  <= 1'b0;
            r_col      <= '0;
            r_row      <= '0;
            r_cx       <= '0;
            r_cy       <= '0;
            r_scan_end <= 1'b0;
            oX         <= '0;
            oY         <= '0;
            oColour    <= '0;
            oPlot      <= 1'b0;
            oDone      <= 1'b0;
        end else begin
            oPlot <= 1'b0;
            if (w_accepting) begin
                if (iLoadX)
                    r_x <= iXY_Coord;
                if (iBlack) begin
                    r_state    <= S_CLEAR;
                    r_cx       <= '0;
                    r_cy       <= '0;
                    r_scan_end <= 1'b0;
                    oDone      <= 1'b0;
                end else if (iPlotBox) begin
                    r_state    <= S_DRAW;
                    r_y        <= iXY_Coord[Y_WIDTH-1:0];
                    r_colour   <= iColour;
                    r_w        <= iBoxW;
                    r_h        <= iBoxH;
                    r_outline  <= iOutline;
                    r_col      <= '0;
                    r_row      <= '0;
                    r_scan_end <= (iBoxW == '0) || (iBoxH == '0);
                    oDone      <= 1'b0;
                end
            end else if (r_scan_end) begin
                // One drain cycle after the last scan position before signalling done.
                r_state <= S_DONE;
                oDone   <= 1'b1;
            end else if (r_state == S_DRAW) begin
                oX      <= w_px[X_WIDTH-1:0];
                oY      <= w_py[Y_WIDTH-1:0];
                oColour <= r_colour;
                oPlot   <= w_on;
                if (w_col_last) begin
                    r_col <= '0;
                    if (w_row_last)
                        r_scan_end <= 1'b1;
                    else
                        r_row <= r_row + SIZE_WIDTH'(1);
                end else begin
                    r_col <= r_col + SIZE_WIDTH'(1);
                end
            end else begin
                oX      <= X_WIDTH'(r_cx);
                oY      <= Y_WIDTH'(r_cy);
                oColour <= '0;
                oPlot   <= 1'b1;
                if (r_cx == CX_LAST) begin
                    r_cx <= '0;
                    if (r_cy == CY_LAST)
                        r_scan_end <= 1'b1;
                    else
                        r_cy <= r_cy + CY_W'(1);
                end else begin
                    r_cx <= r_cx + CX_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_rect_plotter.sv
// Scoreboard bench for vga_rect_plotter: a raster-order reference model queues expected
// pixel writes with their cycle stamps; a negedge monitor pops them as oPlot pulses appear.
module tb_vga_rect_plotter;
    logic       iClock = 1'b0;
    logic       iResetn = 1'b0;
    logic       iLoadX = 1'b0, iPlotBox = 1'b0, iBlack = 1'b0, iOutline = 1'b0;
    logic [7:0] iXY_Coord = '0;
    logic [2:0] iColour = '0;
    logic [4:0] iBoxW = '0, iBoxH = '0;
    logic [7:0] oX;
    logic [6:0] oY;
    logic [2:0] oColour;
    logic       oPlot, oDone;

    vga_rect_plotter dut (
        .iClock(iClock), .iResetn(iResetn), .iLoadX(iLoadX), .iPlotBox(iPlotBox),
        .iBlack(iBlack), .iXY_Coord(iXY_Coord), .iColour(iColour), .iBoxW(iBoxW),
        .iBoxH(iBoxH), .iOutline(iOutline), .oX(oX), .oY(oY), .oColour(oColour),
        .oPlot(oPlot), .oDone(oDone)
    );

    always #5 iClock = ~iClock;

    typedef struct { int x; int y; int c; int cyc; } pix_t;
    pix_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0, n_pass = 0;
    int   n_plots = 0;
    int   model_x = 0;

    always @(posedge iClock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    always @(negedge iClock) begin
        if (iResetn === 1'b1 && oPlot === 1'b1) begin
            pix_t p;
            n_plots++;
            if (exp_q.size() == 0) begin
                check("unexpected_plot_x", int'(oX), -1);
            end else begin
                p = exp_q.pop_front();
                check("pix_x", int'(oX), p.x);
                check("pix_y", int'(oY), p.y);
                check("pix_colour", int'(oColour), p.c);
                check("pix_cycle", cyc, p.cyc);
            end
        end
    end

    // Reference: every position in raster order; keep the ones that land on screen
    // and (in outline mode) lie on the box border.
    function automatic int model_box(int x0, int y0, int c, int w, int h, bit outl, int a);
        int cnt = 0;
        for (int r = 0; r < h; r++)
            for (int k = 0; k < w; k++) begin
                int x = x0 + k, y = y0 + r;
                bit border = (k == 0) || (r == 0) || (k == w - 1) || (r == h - 1);
                if (x < 160 && y < 120 && (!outl || border)) begin
                    exp_q.push_back('{x: x, y: y, c: c, cyc: a + r * w + k + 1});
                    cnt++;
                end
            end
        return cnt;
    endfunction

    function automatic int model_clear(int a);
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++)
                exp_q.push_back('{x: x, y: y, c: 0, cyc: a + y * 160 + x + 1});
        return 160 * 120;
    endfunction

    task automatic load_x(input int x, input bit prev_done);
        @(negedge iClock);
        iLoadX = 1'b1; iXY_Coord = 8'(x);
        @(negedge iClock);
        iLoadX = 1'b0;
        model_x = x;
        check("loadx_keeps_done", int'(oDone), int'(prev_done));
    endtask

    // Drives the command at a negedge, returns accept-edge cycle, expected scan length and plot count.
    task automatic accept(input int ycoord, input int c, input int w, input int h, input bit outl,
                          input bit plot, input bit black, output int a, output int n, output int np);
        iXY_Coord = 8'(ycoord); iColour = 3'(c); iBoxW = 5'(w); iBoxH = 5'(h);
        iOutline = outl; iPlotBox = plot; iBlack = black;
        a = cyc + 1;
        n_plots = 0;
        if (black) begin np = model_clear(a); n = 19200; end
        else begin np = model_box(model_x, ycoord % 128, c, w, h, outl, a); n = w * h; end
        @(negedge iClock);
        iPlotBox = 1'b0; iBlack = 1'b0;
        check("done_cleared_on_accept", int'(oDone), 0);
    endtask

    task automatic finish(input int a, input int n, input int np, input bit junk);
        bit early = 1'b0;
        int t = 0;
        for (int i = 1; i <= n; i++) begin
            if (junk) begin
                iLoadX = 1'($urandom); iPlotBox = 1'($urandom); iBlack = ($urandom % 8) == 0;
                iXY_Coord = 8'($urandom); iBoxW = 5'($urandom); iBoxH = 5'($urandom);
            end
            @(negedge iClock);
            if (oDone) early = 1'b1;
        end
        iLoadX = 1'b0; iPlotBox = 1'b0; iBlack = 1'b0;
        check("done_not_early", int'(early), 0);
        do begin @(negedge iClock); t++; end while (!oDone && t < 40);
        check("done_cycle", cyc, a + n + 1);
        check("done_plot_low", int'(oPlot), 0);
        #1;
        check("queue_drained", exp_q.size(), 0);
        check("plot_count", n_plots, np);
        exp_q.delete();
    endtask

    initial begin
        int a, n, np;
        bit held;
        // 1: asynchronous reset asserted between edges
        #3 iResetn = 1'b1;
        #4 iResetn = 1'b0;
        #1 check("reset_outputs", int'({oX, oY, oColour, oPlot, oDone}), 0);
        @(negedge iClock); @(negedge iClock);
        iResetn = 1'b1;
        @(negedge iClock);

        // 2: filled 4x4 at (10,20), then oDone held for 100 cycles
        load_x(10, 1'b0);
        accept(20, 5, 4, 4, 1'b0, 1'b1, 1'b0, a, n, np);
        finish(a, n, np, 1'b0);
        held = 1'b1;
        repeat (100) begin
            @(negedge iClock);
            if (!oDone || oPlot) held = 1'b0;
        end
        check("done_held_100", int'(held), 1);

        // 3: outline 4x3 at origin
        load_x(0, 1'b1);
        accept(0, 3, 4, 3, 1'b1, 1'b1, 1'b0, a, n, np);
        finish(a, n, np, 1'b0);
        check("outline_plots", np, 10);

        // 4: clipping at the bottom-right corner
        load_x(158, 1'b1);
        accept(118, 6, 4, 3, 1'b0, 1'b1, 1'b0, a, n, np);
        finish(a, n, np, 1'b0);
        check("clip_plots", np, 4);

        // 5: clear colliding with a box command, box pulses during the clear
        accept(30, 7, 8, 8, 1'b0, 1'b1, 1'b1, a, n, np);
        finish(a, n, np, 1'b1);

        // randomized boxes, with ignored command noise while drawing
        for (int i = 0; i < 14; i++) begin
            if ($urandom % 4 != 0) load_x(int'($urandom % 256), 1'b1);
            accept(int'($urandom % 256), int'($urandom % 8), int'($urandom % 32),
                   int'($urandom % 32), 1'($urandom), 1'b1, 1'b0, a, n, np);
            finish(a, n, np, 1'b1);
        end

        // 6: reset in the middle of the 4x4 draw, then a zero-width box
        load_x(10, 1'b1);
        accept(20, 5, 4, 4, 1'b0, 1'b1, 1'b0, a, n, np);
        repeat (5) @(negedge iClock);
        #2 iResetn = 1'b0;
        #1 check("midrun_reset_outputs", int'({oX, oY, oColour, oPlot, oDone}), 0);
        exp_q.delete();
        model_x = 0;
        @(negedge iClock); @(negedge iClock);
        iResetn = 1'b1;
        repeat (3) @(negedge iClock);
        check("idle_after_reset", int'({oPlot, oDone}), 0);
        accept(40, 2, 0, 9, 1'b0, 1'b1, 1'b0, a, n, np);
        finish(a, n, np, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/vga_rect_plotter.md
Name: vga_rect_plotter

Overview:
Parametrised rectangle/clear-screen pixel generator for the VGA adapter path. It latches a box origin, size, colour and mode, then emits exactly one pixel write per clock in raster order. It supports filled or outline boxes, clips pixels outside the screen, and clears the whole screen to black. It sits between the user-input/control logic and the VGA adapter's x/y/colour/plot write port.

Parameters:
X_SCREEN_PIXELS, 160, horizontal resolution
Y_SCREEN_PIXELS, 120, vertical resolution
X_WIDTH, 8, width of oX, iXY_Coord and latched X
Y_WIDTH, 7, width of oY and latched Y
COLOUR_WIDTH, 3, colour bits
SIZE_WIDTH, 5, width of iBoxW/iBoxH (box side 0..31)

Ports:
iClock  input  1  system clock, all state on rising edge
iResetn  input  1  asynchronous active-low reset
iLoadX  input  1  latch iXY_Coord as X origin (idle/done only)
iPlotBox  input  1  latch Y origin, colour, size, mode; start box draw
iBlack  input  1  start full-screen clear to colour 0
iXY_Coord  input  X_WIDTH  coordinate bus; Y uses low Y_WIDTH bits
iColour  input  COLOUR_WIDTH  box colour
iBoxW  input  SIZE_WIDTH  box width in pixels
iBoxH  input  SIZE_WIDTH  box height in pixels
iOutline  input  1  1 = border pixels only, 0 = filled
oX  output  X_WIDTH  pixel x
oY  output  Y_WIDTH  pixel y
oColour  output  COLOUR_WIDTH  pixel colour
oPlot  output  1  pixel write enable, one pixel per high cycle
oDone  output  1  command finished; held until next command accepted

Behaviour:
- Clock and reset: one clock iClock. Reset iResetn is asynchronous, active-low. While low, all outputs are 0, all latched registers and counters are 0, and the state is IDLE. This holds on reset mid-operation too; there is no resume.
- States: IDLE, DRAW, CLEAR, DONE. Commands are accepted only in IDLE or DONE.
- Command acceptance:
  - iLoadX in IDLE/DONE latches X. It does not change state or clear oDone.
  - iBlack has priority over iPlotBox in the same cycle.
  - iPlotBox latches Y, colour, W, H and outline, then goes to DRAW.
  - iBlack goes to CLEAR.
  - Accepting any command clears oDone on the same edge.
  - All of iLoadX, iPlotBox and iBlack are ignored while in DRAW or CLEAR.
- Scan:
  - Column counter (SIZE_WIDTH) and row counter advance one pixel per cycle, column fastest.
  - DRAW visits exactly W*H positions. CLEAR visits X_SCREEN_PIXELS*Y_SCREEN_PIXELS positions, with a counter sized to those.
- Output timing:
  - oX/oY/oColour/oPlot are registered.
  - For cycle k after the accept edge (k = 1..N), the outputs present scan position k-1.
  - On cycle N+1 the state is DONE, oPlot is 0 and oDone is 1.
- Arithmetic:
  - Pixel x = X + col and y = Y + row, computed one bit wider than the output.
  - oPlot is 0 for that cycle (clipped) if x >= X_SCREEN_PIXELS or y >= Y_SCREEN_PIXELS. The scan still consumes the cycle, so latency is deterministic.
  - oX/oY carry the truncated sum even when clipped.
- Outline mode: oPlot is 1 only when col==0, col==W-1, row==0 or row==H-1, and the pixel is not clipped. Interior cycles are still consumed.
- CLEAR: oColour is 0 and oPlot is 1 for every position, from (0,0) to (X_SCREEN_PIXELS-1, Y_SCREEN_PIXELS-1).
- Degenerate size: W==0 or H==0 gives zero plots; DONE on cycle 1 after accept. W==1 or H==1 with outline plots every pixel.
- Idle outputs: when not plotting, oPlot is 0. oX/oY/oColour hold their last values.
- DONE: identical to IDLE except oDone is 1. oDone stays 1 indefinitely until the next accept.

Test Plan:
1. Reset: assert iResetn=0 asynchronously between edges. Required: oX=oY=oColour=oPlot=oDone=0 immediately.
2. Filled box: iLoadX with coord 10, then iPlotBox with coord 20, colour 5, W=4, H=4, iOutline=0. Required: 16 consecutive oPlot=1 cycles at (10,20),(11,20)..(13,23), colour 5. Cycle 17: oPlot=0, oDone=1, held 100 cycles.
3. Outline box: X=0, Y=0, W=4, H=3, iOutline=1. Required: 12 scan cycles with 10 plots; (1,1) and (2,1) have oPlot=0.
4. Clipping: X=158, Y=118, W=4, H=3. Required: 12 scan cycles; only (158,118),(159,118),(158,119),(159,119) plotted; oDone on cycle 13.
5. Clear with collision: iBlack and iPlotBox high in the same cycle. Required: CLEAR wins; 19200 plots of colour 0, last at (159,119). iPlotBox pulses during the clear are ignored; oDone on cycle 19201.
6. Reset and zero size:
   - Reset mid-draw at cycle 5 of test 2. Required: outputs 0 at once, then IDLE.
   - After release, iPlotBox with W=0. Required: no plots, oDone=1 on the next cycle.
